// File: rtl/bdsr_ctrl_pkg.sv
// Shared constants and state encoding for the bidirectional shift-register sequencer.
package bdsr_ctrl_pkg;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_LEFT  = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/bdsr_seq_ctrl_if.sv
// Command/data bundle between a host and the shift sequencer.
// The rot signal exists only when BDSR_ROTATE_EN is defined.
interface bdsr_seq_ctrl_if;
  import bdsr_ctrl_pkg::*;

  logic             start;
  logic             dir;
  logic [CNT_W-1:0] nshift;
  logic             load;
  logic [WIDTH-1:0] load_data;
  logic             ser_in;
  logic [WIDTH-1:0] q;
  logic             ser_out;
  logic             busy;
  logic             done;
`ifdef BDSR_ROTATE_EN
  logic             rot;
`endif

  modport master (
    output start, dir, nshift, load, load_data, ser_in,
`ifdef BDSR_ROTATE_EN
    output rot,
`endif
    input  q, ser_out, busy, done
  );

  modport slave (
    input  start, dir, nshift, load, load_data, ser_in,
`ifdef BDSR_ROTATE_EN
    input  rot,
`endif
    output q, ser_out, busy, done
  );

endinterface

// File: rtl/bdsr_shift_core.sv
// 4-bit bidirectional shift register with parallel load; holds q and the last bit shifted out.
module bdsr_shift_core
  import bdsr_ctrl_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             dir,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             ser_out
);

  logic [WIDTH-1:0] q_r;
  logic             ser_out_r;

  // Register update: load has priority; ser_out only changes on a shift.
  always_ff @(posedge clock) begin
    if (reset) begin
      q_r       <= {WIDTH{1'b0}};
      ser_out_r <= 1'b0;
    end else if (load_en) begin
      q_r <= load_data;
    end else if (shift_en) begin
      if (dir == DIR_RIGHT) begin
        q_r       <= {ser_in, q_r[WIDTH-1:1]};
        ser_out_r <= q_r[0];
      end else begin
        q_r       <= {q_r[WIDTH-2:0], ser_in};
        ser_out_r <= q_r[WIDTH-1];
      end
    end
  end

  assign q       = q_r;
  assign ser_out = ser_out_r;

endmodule

// File: rtl/bdsr_seq_ctrl.sv
// Start/busy/done sequencer driving bdsr_shift_core for a programmed number of shifts.
// Optional rotate mode enabled by defining BDSR_ROTATE_EN.
module bdsr_seq_ctrl
  import bdsr_ctrl_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  bdsr_seq_ctrl_if.slave bus
);

  state_e           state_r, state_nxt_s;
  logic [CNT_W-1:0] count_r, count_nxt_s;
  logic             dir_r;
  logic             busy_r, done_r;
  logic             load_en_s, shift_en_s, latch_en_s;
  logic             feed_s;
  logic [WIDTH-1:0] q_s;
  logic             ser_out_s;
`ifdef BDSR_ROTATE_EN
  logic             rot_r;
`endif

  // State, counter and registered status flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
      count_r <= {CNT_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      count_r <= count_nxt_s;
      busy_r  <= (state_nxt_s == ST_SHIFT);
      done_r  <= (state_nxt_s == ST_DONE);
    end
  end

  // Per-sequence mode bits, captured only when a start is accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      dir_r <= DIR_LEFT;
`ifdef BDSR_ROTATE_EN
      rot_r <= 1'b0;
`endif
    end else if (latch_en_s) begin
      dir_r <= bus.dir;
`ifdef BDSR_ROTATE_EN
      rot_r <= bus.rot;
`endif
    end
  end

  // Next-state logic; requests are only looked at in IDLE/DONE and load beats start.
  always_comb begin
    state_nxt_s = state_r;
    count_nxt_s = count_r;
    load_en_s   = 1'b0;
    shift_en_s  = 1'b0;
    latch_en_s  = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (bus.load) begin
          load_en_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (bus.start) begin
          latch_en_s = 1'b1;
          if (bus.nshift != {CNT_W{1'b0}}) begin
            count_nxt_s = bus.nshift;
            state_nxt_s = ST_SHIFT;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        shift_en_s  = 1'b1;
        count_nxt_s = count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        if (count_r == {{(CNT_W-1){1'b0}}, 1'b1}) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        count_nxt_s = {CNT_W{1'b0}};
      end
    endcase
  end

  // Serial feed: in rotate mode the outgoing bit re-enters at the opposite end.
  always_comb begin
    feed_s = bus.ser_in;
`ifdef BDSR_ROTATE_EN
    if (rot_r) begin
      feed_s = (dir_r == DIR_RIGHT) ? q_s[0] : q_s[WIDTH-1];
    end else begin
      feed_s = bus.ser_in;
    end
`endif
  end

  bdsr_shift_core u_core (
    .clock     (clock),
    .reset     (reset),
    .load_en   (load_en_s),
    .load_data (bus.load_data),
    .shift_en  (shift_en_s),
    .dir       (dir_r),
    .ser_in    (feed_s),
    .q         (q_s),
    .ser_out   (ser_out_s)
  );

  assign bus.q       = q_s;
  assign bus.ser_out = ser_out_s;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;

endmodule
